// File: rtl/fsm_led_sequencer.sv
// Button/mode-driven LED pattern sequencer: synchronised, debounced push-button
// steps an LED_W-bit pattern manually or from a tick divider, with pause.
module fsm_led_sequencer #(
    parameter int unsigned LED_W     = 3,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned TICK_DIV  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic [2:0]       mode,
    output logic [LED_W-1:0] led,
    output logic [1:0]       state,
    output logic             step_pulse
);

    localparam int unsigned DBC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned TDC_W = $clog2(TICK_DIV);
    localparam logic [LED_W-1:0] CNT_MAX  = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] RING_MAX = LED_W'(LED_W - 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);
    localparam logic [TDC_W-1:0] TDC_LAST = TDC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic             btn_meta, btn_s, btn_db, btn_db_d;
    logic [2:0]       mode_meta, mode_s;
    logic [DBC_W-1:0] dbc;
    logic [LED_W-1:0] cnt, cnt_n, cnt_inc, cnt_wrap;
    logic [TDC_W-1:0] tdc, tdc_n;
    logic [1:0]       pat_q, pat_n;
    logic             step_n, do_step, press, auto_en, tick;

    // Input synchronisers and debounce filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            mode_meta <= 3'b000;
            mode_s    <= 3'b000;
            dbc       <= '0;
            btn_db    <= 1'b0;
            btn_db_d  <= 1'b0;
        end else begin
            btn_meta  <= btn;
            btn_s     <= btn_meta;
            mode_meta <= mode;
            mode_s    <= mode_meta;
            btn_db_d  <= btn_db;
            if (btn_s == btn_db) begin
                dbc <= '0;
            end else if (dbc == DBC_LAST) begin
                btn_db <= btn_s;
                dbc    <= '0;
            end else begin
                dbc <= dbc + DBC_W'(1);
            end
        end
    end

    assign press    = btn_db & ~btn_db_d;
    assign auto_en  = mode_s[2];
    assign tick     = (tdc == TDC_LAST);
    assign cnt_wrap = (pat_q == 2'b10) ? RING_MAX : CNT_MAX;
    assign cnt_inc  = (cnt == cnt_wrap) ? '0 : cnt + LED_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt        <= '0;
            tdc        <= '0;
            pat_q      <= 2'b00;
            step_pulse <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt        <= cnt_n;
            tdc        <= tdc_n;
            pat_q      <= pat_n;
            step_pulse <= step_n;
        end
    end

    // Next state; tdc only survives while staying in AUTO
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt;
        tdc_n   = '0;
        pat_n   = pat_q;
        step_n  = 1'b0;
        do_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_n = auto_en ? AUTO : MANUAL;
                    cnt_n   = '0;
                    pat_n   = mode_s[1:0];
                end
            end
            MANUAL: begin
                if (auto_en)    state_n = AUTO;
                else if (press) do_step = 1'b1;
            end
            AUTO: begin
                if (!auto_en) begin
                    state_n = MANUAL;
                end else if (press) begin
                    state_n = PAUSE;
                end else begin
                    tdc_n   = tick ? '0 : tdc + TDC_W'(1);
                    do_step = tick;
                end
            end
            PAUSE: begin
                if (!auto_en)   state_n = MANUAL;
                else if (press) state_n = AUTO;
            end
            default: state_n = IDLE;
        endcase

        if (do_step) begin
            cnt_n  = cnt_inc;
            step_n = 1'b1;
        end

        // A pattern switch restarts the sequence and suppresses any step
        if (state_q != IDLE && mode_s[1:0] != pat_q) begin
            pat_n  = mode_s[1:0];
            cnt_n  = '0;
            tdc_n  = '0;
            step_n = 1'b0;
        end
    end

    always_comb begin
        led = '0;
        if (state_q != IDLE) begin
            case (pat_q)
                2'b00:   led = cnt;
                2'b01:   led = ~cnt;
                2'b10:   led = LED_W'(1) << cnt;
                default: led = cnt ^ (cnt >> 1);
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fsm_led_sequencer.sv
// Self-checking bench for fsm_led_sequencer: directed scenarios plus random
// button/mode/reset traffic compared against a cycle-level behavioural model.
module tb_fsm_led_sequencer;

    localparam int unsigned LED_W     = 3;
    localparam int unsigned DB_CYCLES = 4;
    localparam int unsigned TICK_DIV  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [LED_W-1:0] led;
    logic [1:0]       state;
    logic             step_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsm_led_sequencer #(
        .LED_W(LED_W), .DB_CYCLES(DB_CYCLES), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .mode(mode),
        .led(led), .state(state), .step_pulse(step_pulse)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integers, sequence position advanced modulo period
    int m_b1, m_bs, m_db, m_dbd, m_run;
    int m_m1, m_ms;
    int m_st, m_pos, m_pat, m_age, m_step;

    function automatic void model_reset();
        m_b1 = 0; m_bs = 0; m_db = 0; m_dbd = 0; m_run = 0;
        m_m1 = 0; m_ms = 0;
        m_st = 0; m_pos = 0; m_pat = 0; m_age = 0; m_step = 0;
    endfunction

    function automatic int period(input int pat);
        return (pat == 2) ? LED_W : (1 << LED_W);
    endfunction

    function automatic int model_led();
        int all1 = (1 << LED_W) - 1;
        if (m_st == 0) return 0;
        case (m_pat)
            0:       return m_pos;
            1:       return all1 - m_pos;
            2:       return 1 << m_pos;
            default: return m_pos ^ (m_pos / 2);
        endcase
    endfunction

    function automatic void model_edge(input int b, input int m);
        int press = (m_db == 1 && m_dbd == 0) ? 1 : 0;
        int aen   = (m_ms >> 2) & 1;
        int sel   = m_ms & 3;
        int nst   = m_st;
        int npos  = m_pos;
        int nage  = 0;
        int nstep = 0;
        if (m_st == 0) begin
            if (press == 1) begin
                nst   = (aen == 1) ? 2 : 1;
                npos  = 0;
                m_pat = sel;
            end
        end else if (m_st == 1) begin
            if (aen == 1) nst = 2;
            else if (press == 1) begin npos = (m_pos + 1) % period(m_pat); nstep = 1; end
        end else if (m_st == 2) begin
            if (aen == 0) nst = 1;
            else if (press == 1) nst = 3;
            else begin
                nage = m_age + 1;
                if (nage == TICK_DIV) begin
                    nage  = 0;
                    npos  = (m_pos + 1) % period(m_pat);
                    nstep = 1;
                end
            end
        end else begin
            if (aen == 0) nst = 1;
            else if (press == 1) nst = 2;
        end
        if (m_st != 0 && sel != m_pat) begin
            m_pat = sel; npos = 0; nage = 0; nstep = 0;
        end
        m_st = nst; m_pos = npos; m_age = nage; m_step = nstep;
        // debounce: accept btn_s after DB_CYCLES consecutive disagreeing samples
        m_dbd = m_db;
        if (m_bs == m_db) m_run = 0;
        else if (m_run + 1 >= DB_CYCLES) begin m_db = m_bs; m_run = 0; end
        else m_run++;
        m_bs = m_b1; m_b1 = b;
        m_ms = m_m1; m_m1 = m;
    endfunction

    task automatic cycle(input logic b, input logic [2:0] m, input logic r);
        @(negedge clk);
        btn = b; mode = m; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(int'(b), int'(m));
        #1;
        check("led", int'(led), model_led());
        check("state", int'(state), m_st);
        check("step_pulse", int'(step_pulse), m_step);
    endtask

    int gray[8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    initial begin
        logic       rb;
        logic [2:0] rm;
        int         hold;
        int         mhold;

        model_reset();
        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            cycle(1'($urandom), 3'($urandom), 1'b1);
            check("rst_led", int'(led), 0);
            check("rst_state", int'(state), 0);
            check("rst_step", int'(step_pulse), 0);
        end

        // short glitch: 3 cycles high must not register
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'b000, 1'b0);
        check("glitch_state", int'(state), 0);

        // press latency: state changes exactly at E7
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 3'b000, 1'b0);
            if (i == 6) check("press_e6_state", int'(state), 0);
            if (i == 7) begin
                check("press_e7_state", int'(state), 1);
                check("press_e7_led", int'(led), 0);
                check("press_e7_step", int'(step_pulse), 0);
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 1'b0);

        // manual up: 8 presses wrap back to 000
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 7; i++) cycle(1'b1, 3'b000, 1'b0);
            check("manual_up_led", int'(led), (p + 1) % 8);
            for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 1'b0);
        end

        // auto Gray from a fresh reset
        cycle(1'b0, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111, 1'b0);
        for (int i = 1; i <= 7; i++) cycle(1'b1, 3'b111, 1'b0);
        check("auto_entry_state", int'(state), 2);
        check("auto_entry_led", int'(led), 0);
        for (int j = 0; j < 8; j++) begin
            for (int t = 0; t < 8; t++) cycle((j == 0 && t < 3) ? 1'b1 : 1'b0, 3'b111, 1'b0);
            check("gray_led", int'(led), gray[j]);
            check("gray_step", int'(step_pulse), 1);
        end
        for (int t = 0; t < 8; t++) cycle(1'b0, 3'b111, 1'b0);
        check("gray_wrap_led", int'(led), 1);

        // pause freezes, resume restarts the tick period
        for (int i = 0; i < 7; i++) cycle(1'b1, 3'b111, 1'b0);
        check("pause_state", int'(state), 3);
        for (int i = 0; i < 50; i++) cycle((i < 3) ? 1'b1 : 1'b0, 3'b111, 1'b0);
        check("pause_frozen_led", int'(led), 1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 3'b111, 1'b0);
        check("resume_state", int'(state), 2);
        for (int i = 0; i < 8; i++) cycle((i < 3) ? 1'b1 : 1'b0, 3'b111, 1'b0);
        check("resume_step_led", int'(led), 3);

        // asynchronous reset mid-AUTO clears led before the next edge
        #3 rst = 1'b1;
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_state", int'(state), 0);
        model_reset();
        cycle(1'b0, 3'b000, 1'b1);

        // random traffic
        rb = 1'b0; rm = 3'b000; hold = 0; mhold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                rb   = ~rb;
                hold = $urandom_range(1, 14);
            end
            hold--;
            if (mhold == 0) begin
                rm    = 3'($urandom_range(0, 7));
                mhold = $urandom_range(10, 250);
            end
            mhold--;
            cycle(rb, rm, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
